// File: rtl/perf_event_counter.sv
// Cycle counter plus NUM_EVENTS event counters, read one channel per request.
// Build option: define PERF_SATURATE_EN to make counters saturate, not wrap.
module perf_event_counter #(
    parameter int NUM_EVENTS = 4,
    parameter int CNT_WIDTH  = 32,
    parameter int MAX_CYCLES = 64,
    parameter int SEL_W      = $clog2(NUM_EVENTS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  clear_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  rd_req_i,
    input  logic [SEL_W-1:0]      rd_sel_i,
    output logic                  rd_valid_o,
    output logic [CNT_WIDTH-1:0]  rd_data_o,
    output logic                  running_o,
    output logic                  done_o,
    output logic [NUM_EVENTS:0]   overflow_o
);

    localparam int NCNT = NUM_EVENTS + 1;
    localparam int CYC  = NUM_EVENTS;
    localparam logic [CNT_WIDTH-1:0] LAST_CYC =
        (MAX_CYCLES > 0) ? CNT_WIDTH'(MAX_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q [NCNT];
    logic [CNT_WIDTH-1:0]   cnt_d [NCNT];
    logic [NUM_EVENTS:0]    ovf_q, ovf_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [CNT_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                   running_q, running_d;
    logic                   done_q, done_d;
    logic [NUM_EVENTS:0]    hit;

    // The cycle counter is simply a channel whose event is always present.
    assign hit = {1'b1, event_i};

    // Window state machine and counter increments; clear overrides all.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int k = 0; k < NCNT; k++) begin
                    if (hit[k]) begin
                        if (&cnt_q[k]) begin
                            ovf_d[k] = 1'b1;
`ifdef PERF_SATURATE_EN
                            cnt_d[k] = cnt_q[k];
`else
                            cnt_d[k] = '0;
`endif
                        end else begin
                            cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
                        end
                    end
                end
                if (MAX_CYCLES != 0 && cnt_q[CYC] == LAST_CYC) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (clear_i) begin
            state_d = S_IDLE;
            cnt_d   = '{default: '0};
            ovf_d   = '0;
        end
    end

    // Read port returns the pre-increment value; out-of-range selects read 0.
    always_comb begin
        rd_valid_d = rd_req_i;
        rd_data_d  = rd_data_q;
        if (rd_req_i) begin
            rd_data_d = '0;
            for (int k = 0; k < NCNT; k++) begin
                if (rd_sel_i == SEL_W'(k)) begin
                    rd_data_d = cnt_q[k];
                end
            end
        end
    end

    // Status outputs follow the next state so they flip with the state flop.
    always_comb begin
        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    // All state and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '{default: '0};
            ovf_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            running_q  <= running_d;
            done_q     <= done_d;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign running_o  = running_q;
    assign done_o     = done_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_perf_event_counter.sv
// Bench for perf_event_counter: two instances (32-bit/64-cycle window and
// 8-bit/unlimited) share stimulus and are checked against unbounded counts.
module tb_perf_event_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       clear;
    logic [3:0] ev;
    logic       rd_req;
    logic [2:0] sel;

    logic        rv0, run0, done0;
    logic [31:0] rd0;
    logic [4:0]  ov0;
    logic        rv1, run1, done1;
    logic [7:0]  rd1;
    logic [4:0]  ov1;

    int n_checks = 0;
    int n_fail   = 0;

    longint cnt_m [2][5];
    int     mode_m [2];
    logic   mv [2];
    longint md [2];

    always #5 clk = ~clk;

    perf_event_counter #(
        .NUM_EVENTS(4), .CNT_WIDTH(32), .MAX_CYCLES(64)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
        .event_i(ev), .rd_req_i(rd_req), .rd_sel_i(sel),
        .rd_valid_o(rv0), .rd_data_o(rd0), .running_o(run0),
        .done_o(done0), .overflow_o(ov0)
    );

    perf_event_counter #(
        .NUM_EVENTS(4), .CNT_WIDTH(8), .MAX_CYCLES(0)
    ) u_dut_ovf (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
        .event_i(ev), .rd_req_i(rd_req), .rd_sel_i(sel),
        .rd_valid_o(rv1), .rd_data_o(rd1), .running_o(run1),
        .done_o(done1), .overflow_o(ov1)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint lim(int d);
        return longint'(1) << (d == 0 ? 32 : 8);
    endfunction

    function automatic int maxc(int d);
        return d == 0 ? 64 : 0;
    endfunction

    // What a counter of finite width shows for a true event count c.
    function automatic longint view(int d, longint c);
`ifdef PERF_SATURATE_EN
        return (c >= lim(d)) ? lim(d) - 1 : c;
`else
        return c % lim(d);
`endif
    endfunction

    // mode: 0 idle, 1 measuring, 2 window finished
    task automatic model_step(int d);
        if (!rst) begin
            mode_m[d] = 0;
            for (int k = 0; k < 5; k++) cnt_m[d][k] = 0;
            mv[d] = 1'b0;
            md[d] = 0;
            return;
        end
        mv[d] = rd_req;
        if (rd_req) md[d] = (sel <= 3'd4) ? view(d, cnt_m[d][int'(sel)]) : 0;
        if (clear) begin
            mode_m[d] = 0;
            for (int k = 0; k < 5; k++) cnt_m[d][k] = 0;
        end else if (mode_m[d] == 0) begin
            if (start) mode_m[d] = 1;
        end else if (mode_m[d] == 1) begin
            for (int k = 0; k < 4; k++) if (ev[k]) cnt_m[d][k]++;
            cnt_m[d][4]++;
            if (maxc(d) != 0 && cnt_m[d][4] == longint'(maxc(d)))
                mode_m[d] = 2;
        end
    endtask

    task automatic compare(int d, logic v, longint data, logic r,
                           logic dn, logic [4:0] ov);
        logic [4:0] eov;
        for (int k = 0; k < 5; k++) eov[k] = (cnt_m[d][k] >= lim(d));
        check($sformatf("d%0d_valid", d), 64'(v), 64'(mv[d]));
        check($sformatf("d%0d_data", d), 64'(data), 64'(md[d]));
        check($sformatf("d%0d_running", d), 64'(r), 64'(mode_m[d] == 1));
        check($sformatf("d%0d_done", d), 64'(dn), 64'(mode_m[d] == 2));
        check($sformatf("d%0d_overflow", d), 64'(ov), 64'(eov));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare(0, rv0, longint'(rd0), run0, done0, ov0);
        compare(1, rv1, longint'(rd1), run1, done1, ov1);
    endtask

    task automatic rd(input logic [2:0] s);
        rd_req = 1'b1;
        sel    = s;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic clr_start();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; clear = 1'b0;
        ev = '0; rd_req = 1'b0; sel = '0;
        tick();
        tick();
        check("rst_valid", 64'(rv0), 64'(0));
        check("rst_data", 64'(rd0), 64'(0));
        rst = 1'b1;

        // Idle: events ignored without start
        ev = 4'hF;
        for (int i = 0; i < 10; i++) tick();
        for (int s = 0; s < 8; s++) begin
            rd(3'(s));
            check("idle_rd", 64'(rd0), 64'(0));
        end
        check("idle_ovf", 64'(ov0), 64'(0));
        check("idle_done", 64'(done0), 64'(0));

        // Bounded window with event 0 every other RUN cycle
        ev = '0;
        clr_start();
        for (int i = 1; i <= 84; i++) begin
            ev = {3'($urandom_range(0, 7)), 1'(i % 2)};
            tick();
            if (i == 63) check("win_not_done", 64'(done0), 64'(0));
            if (i == 64) check("win_done", 64'(done0), 64'(1));
        end
        rd(3'd4);
        check("win_cycles", 64'(rd0), 64'(64));
        rd(3'd0);
        check("win_ev0", 64'(rd0), 64'(32));

        // Clear priority at cycle counter 10, then restart
        clr_start();
        for (int i = 0; i < 10; i++) begin
            ev = 4'($urandom_range(0, 15));
            tick();
        end
        clear = 1'b1;
        ev = 4'hF;
        tick();
        clear = 1'b0;
        ev = '0;
        check("clr_running", 64'(run0), 64'(0));
        for (int s = 0; s < 5; s++) begin
            rd(3'(s));
            check("clr_rd", 64'(rd0), 64'(0));
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rd(3'd4);
        check("restart_cyc", 64'(rd0), 64'(1));

        // Back-to-back reads during RUN
        ev = 4'($urandom_range(0, 15));
        rd_req = 1'b1;
        sel = 3'd0; tick();
        sel = 3'd1; tick();
        sel = 3'd4; tick();
        sel = 3'd7; tick();
        rd_req = 1'b0;
        check("rd_sel7", 64'(rd0), 64'(0));
        check("rd_sel7_valid", 64'(rv0), 64'(1));

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 199) != 0);
            clear  = ($urandom_range(0, 99) == 0);
            start  = ($urandom_range(0, 7) == 0);
            ev     = 4'($urandom_range(0, 15));
            rd_req = 1'($urandom_range(0, 1));
            sel    = 3'($urandom_range(0, 7));
            tick();
        end
        rst = 1'b1; clear = 1'b0; start = 1'b0; rd_req = 1'b0;

        // Overflow on the 8-bit unlimited instance
        ev = '0;
        clr_start();
        ev = 4'b0010;
        for (int i = 0; i < 300; i++) tick();
        ev = '0;
        rd(3'd1);
`ifdef PERF_SATURATE_EN
        check("ovf_ch1", 64'(rd1), 64'(255));
`else
        check("ovf_ch1", 64'(rd1), 64'(44));
`endif
        check("ovf_bit1", 64'(ov1[1]), 64'(1));
        check("ovf_bit4", 64'(ov1[4]), 64'(1));

        // Reset in the middle of a window
        clr_start();
        for (int i = 0; i < 30; i++) begin
            ev = 4'($urandom_range(0, 15));
            tick();
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mrst_running", 64'(run0), 64'(0));
        check("mrst_done", 64'(done0), 64'(0));
        check("mrst_ovf", 64'(ov0), 64'(0));
        check("mrst_valid", 64'(rv0), 64'(0));
        check("mrst_data", 64'(rd0), 64'(0));
        tick();
        rd(3'd4);
        check("mrst_cyc", 64'(rd0), 64'(0));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
